conv2d_mem_responder: RTL and testbench

// - Memory-side responder for the accelerator request/response bus: mem_req_* in, mem_resp_* out.
// - Writes go straight to a single-port synchronous BRAM. Reads return their data in order

---
 rtl/conv2d_mem_responder.sv | 145 ++++++++++++++
 tb/tb_conv2d_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_mem_responder.sv
// rtl/conv2d_mem_responder.sv - memory-side request/response responder in front of a single-port BRAM
// Optional address checking is enabled by defining ACCEL_MEM_ERR_EN.

module conv2d_resp_fifo #(
  parameter  int DWIDTH = 32,
  parameter  int DEPTH  = 4,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  output logic [CW-1:0]     o_count
);
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  // The ready rule upstream guarantees a push never lands on a full FIFO without a pop.
  assign w_pop   = i_pop & (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

module conv2d_mem_responder #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 12,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       mem_req_addr,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [DWIDTH-1:0] mem_req_data,
  input  logic              mem_req_write,
  output logic [DWIDTH-1:0] mem_resp_data,
  output logic              mem_resp_valid,
  input  logic              mem_resp_ready,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_din,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              idle,
  output logic              err
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic              r_run;
  logic              r_inflight;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_occ;
  logic              w_fire;
  logic              w_rd_fire;
  logic [DWIDTH-1:0] w_push_data;

  // r_run keeps ready low during reset and for the first edge after release.
  assign w_occ         = w_count + CW'(r_inflight);
  assign mem_req_ready = r_run & (w_occ < CW'(RESP_DEPTH));
  assign w_fire        = mem_req_valid & mem_req_ready;
  assign w_rd_fire     = w_fire & ~mem_req_write;

  assign ram_en   = w_fire;
  assign ram_addr = mem_req_addr[AWIDTH+1:2];
  assign ram_din  = mem_req_data;
  assign idle     = ~r_inflight & (w_count == '0);

`ifdef ACCEL_MEM_ERR_EN
  localparam logic [DWIDTH-1:0] ERR_DATA = DWIDTH'({((DWIDTH + 31) / 32){32'hDEADBEEF}});

  logic w_addr_err;
  logic r_inflight_err;
  logic r_err;

  assign w_addr_err  = (mem_req_addr[1:0] != 2'b00) | (|mem_req_addr[31:AWIDTH+2]);
  assign ram_we      = w_fire & mem_req_write & ~w_addr_err;
  assign w_push_data = r_inflight_err ? ERR_DATA : ram_dout;
  assign err         = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight_err <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_inflight_err <= w_rd_fire & w_addr_err;
      if (w_fire & w_addr_err) r_err <= 1'b1;
    end
  end
`else
  logic w_unused_addr;

  assign w_unused_addr = ^{mem_req_addr[31:AWIDTH+2], mem_req_addr[1:0]};
  assign ram_we        = w_fire & mem_req_write;
  assign w_push_data   = ram_dout;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_rd_fire;
    end
  end

  conv2d_resp_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (mem_resp_ready),
    .o_data      (mem_resp_data),
    .o_valid     (mem_resp_valid),
    .o_count     (w_count)
  );
endmodule

// File: tb/tb_conv2d_mem_responder.sv
// tb/tb_conv2d_mem_responder.sv - self-checking bench for conv2d_mem_responder with a queue-based reference model
// Covers ACCEL_MEM_ERR_EN when the macro is defined for the build.

module tb_conv2d_mem_responder;
  logic        clk;
  logic        rst_n;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_data;
  logic        mem_req_write;
  logic [31:0] mem_resp_data;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [11:0] ram_addr;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        idle;
  logic        err;

  conv2d_mem_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_addr   (mem_req_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_data   (mem_req_data),
    .mem_req_write  (mem_req_write),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .ram_addr       (ram_addr),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .idle           (idle),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] bram [0:4095];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) bram[ram_addr] <= ram_din;
      ram_dout <= bram[ram_addr];
    end
  end

  typedef struct {
    logic [31:0] data;
    int          acc;
  } resp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] m_mem [0:4095];
  resp_t       m_q[$];
  vec_t        vecs[$];
  int          edge_n;
  bit          m_run;
  bit          m_err;
  int          checks;
  int          failures;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic bit addr_err(logic [31:0] a);
`ifdef ACCEL_MEM_ERR_EN
    return (a[1:0] != 2'b00) || (a[31:14] != 18'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=timeout required=completion", name);
  endtask

  task automatic add_vec(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  // One clock cycle: drive, compare against the model at negedge, advance the model at posedge.
  task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit rr, output bit acc, output bit popped, output logic [31:0] pdata);
    bit    exp_ready, exp_valid, fire, aerr;
    resp_t r;
    mem_req_valid  = v;
    mem_req_write  = w;
    mem_req_addr   = a;
    mem_req_data   = d;
    mem_resp_ready = rr;
    @(negedge clk);
    exp_ready = m_run && rst_n && (m_q.size() < 4);
    exp_valid = (m_q.size() > 0) && (edge_n >= m_q[0].acc + 1);
    aerr      = addr_err(a);
    fire      = v && exp_ready;
    check("req_ready", mem_req_ready, exp_ready);
    check("resp_valid", mem_resp_valid, exp_valid);
    if (exp_valid) check("resp_data", mem_resp_data, m_q[0].data);
    check("idle", idle, m_q.size() == 0);
    check("err", err, m_err);
    check("ram_en", ram_en, fire);
    check("ram_we", ram_we, fire && w && !aerr);
    if (fire) check("ram_addr", ram_addr, a[13:2]);
    if (fire && w) check("ram_din", ram_din, d);
    acc    = v && mem_req_ready;
    popped = mem_resp_valid && rr;
    pdata  = mem_resp_data;
    @(posedge clk);
    edge_n++;
    if (exp_valid && rr) void'(m_q.pop_front());
    if (fire && !w) begin
      r.data = aerr ? 32'hDEADBEEF : m_mem[a[13:2]];
      r.acc  = edge_n;
      m_q.push_back(r);
    end
    if (fire && w && !aerr) m_mem[a[13:2]] = d;
    if (fire && aerr) m_err = 1'b1;
    m_run = rst_n;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          acc, popped, done;
    logic [31:0] pdata, a;
    int          n_acc;
    checks = 0; failures = 0; edge_n = 0; m_run = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      bram[i]  = init_word(i);
      m_mem[i] = init_word(i);
    end

    add_vec(1, 32'h40,   32'h11,       32'h0);
    add_vec(0, 32'h40,   32'h0,        32'h11);
    add_vec(1, 32'h44,   32'hCAFEF00D, 32'h0);
    add_vec(1, 32'h44,   32'h12345678, 32'h0);
    add_vec(0, 32'h44,   32'h0,        32'h12345678);
    add_vec(1, 32'h0,    32'hA5A5A5A5, 32'h0);
    add_vec(0, 32'h0,    32'h0,        32'hA5A5A5A5);
    add_vec(1, 32'h3FFC, 32'h0BADF00D, 32'h0);
    add_vec(0, 32'h3FFC, 32'h0,        32'h0BADF00D);
    add_vec(0, 32'h48,   32'h0,        init_word(18));
`ifdef ACCEL_MEM_ERR_EN
    add_vec(0, 32'h41,   32'h0,        32'hDEADBEEF);
    add_vec(1, 32'h4000, 32'h99,       32'h0);
    add_vec(0, 32'h0,    32'h0,        32'hA5A5A5A5);
`else
    add_vec(0, 32'h4040, 32'h0,        32'h11);
    add_vec(1, 32'h8047, 32'h77,       32'h0);
    add_vec(0, 32'h44,   32'h0,        32'h77);
`endif

    rst_n = 1'b0; mem_req_valid = 1'b0; mem_req_write = 1'b0;
    mem_req_addr = '0; mem_req_data = '0; mem_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", mem_req_ready, 1'b0);
    check("rst_resp_valid", mem_resp_valid, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      done = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
        step(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b1, acc, popped, pdata);
        done = acc;
      end
      if (!done) timeout_fail("tbl_accept");
      if (!vecs[i].wr) begin
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
          step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc, popped, pdata);
          done = popped;
        end
        if (done) check("tbl_read_data", pdata, vecs[i].exp);
        else timeout_fail("tbl_response");
      end
    end
`ifdef ACCEL_MEM_ERR_EN
    @(negedge clk);
    check("err_sticky", err, 1'b1);
    @(posedge clk); #1;
`endif

    step(1'b1, 1'b1, 32'h40, 32'h22, 1'b1, acc, popped, pdata);
    step(1'b1, 1'b0, 32'h40, 32'h0,  1'b1, acc, popped, pdata);
    check("lat_accept", acc, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc, popped, pdata);
    check("lat_not_yet", popped, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc, popped, pdata);
    check("lat_2cyc_valid", popped, 1'b1);
    check("lat_2cyc_data", pdata, 32'h22);

    for (int k = 0; k < 12; k++) begin
      step(k < 8, 1'b0, 32'(k * 4), 32'h0, 1'b1, acc, popped, pdata);
      if (k < 8) check("b2b_accept", acc, 1'b1);
      if (k >= 2 && k < 10) begin
        check("b2b_resp", popped, 1'b1);
        check("b2b_data", pdata, m_mem[k-2]);
      end
    end

    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 32'(32'h100 + k * 4), 32'h0, 1'b0, acc, popped, pdata);
      n_acc += int'(acc);
    end
    check("bp_accepts", 32'(n_acc), 32'd4);
    check("bp_ready_low", acc, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 32'(32'h200 + k * 4), 32'h0, 1'b1, acc, popped, pdata);
    done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc, popped, pdata);
      done = (m_q.size() == 0);
    end
    if (!done) timeout_fail("bp_drain");
    @(negedge clk);
    check("bp_idle", idle, 1'b1);
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'(32'h300 + k * 4), 32'h0, 1'b0, acc, popped, pdata);
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", mem_resp_valid, 1'b0);
    check("mid_rst_idle", idle, 1'b1);
    check("mid_rst_req_ready", mem_req_ready, 1'b0);
    m_q.delete();
    m_run = 1'b0;
    m_err = 1'b0;
    for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, acc, popped, pdata);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc, popped, pdata);

    for (int k = 0; k < 600; k++) begin
      logic [17:0] hi;
      logic [11:0] word;
      logic [1:0]  lo;
      word = 12'($urandom_range(0, 31));
      hi   = ($urandom_range(0, 7) == 0) ? 18'($urandom) : 18'd0;
      lo   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
      a    = {hi, word, lo};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, $urandom,
           $urandom_range(0, 3) != 0, acc, popped, pdata);
    end
    done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc, popped, pdata);
      done = (m_q.size() == 0);
    end
    if (!done) timeout_fail("rand_drain");
    @(negedge clk);
    check("final_idle", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
